// File: rtl/bexkat1Def.sv
// Shared bexkat definitions: responder FSM state encoding and the byte-lane
// select patterns that match the CPU's 8/16/32-bit bus accesses.
package bexkat1Def;

    typedef enum bit [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_ACK  = 2'd2
    } resp_state_t;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    // True for the lane patterns the CPU can actually produce (plus the
    // empty select, which completes as a no-op write / full-word read).
    function automatic logic sel_legal(input logic [3:0] sel);
        logic ok;
        ok = 1'b0;
        case (sel)
            SEL_B0, SEL_B1, SEL_B2, SEL_B3,
            SEL_H0, SEL_H1, SEL_W, 4'b0000: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bexkat2_ram_bank.sv
// 2**AW x 32 scratchpad, one independent byte array per lane so each lane
// has its own write enable; the read port is registered (block-RAM style).
module bexkat2_ram_bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   din,
    input  logic          re,
    output logic [31:0]   q
);

    localparam int DEPTH = 2 ** AW;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] q_reg;

            // Per-lane write and registered read of the same address.
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= din[8*gi +: 8];
                end
                if (re) begin
                    q_reg <= lane_mem[addr];
                end
            end

            assign q[8*gi +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/bexkat2_bus_responder.sv
// Bus responder for the bexkat2 CPU: accepts one request at a time, inserts
// WAIT wait states, then completes with a single-cycle ack backed by an
// on-chip RAM bank with byte-lane writes.
// Optional build macro BEXKAT2_BUS_ERR_EN: out-of-range addresses and
// illegal lane selects complete with err_o instead of ack_o; without it
// err_o is tied low and the address aliases modulo the memory depth.
module bexkat2_bus_responder
    import bexkat1Def::*;
#(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    resp_state_t   state_reg, state_next;
    logic [3:0]    count_reg, count_next;
    logic          we_reg;
    logic [AW-1:0] idx_reg;
    logic [3:0]    sel_reg;
    logic [31:0]   dat_reg;
    logic          err_reg;
    logic          dat_valid_reg;

    logic          accept;
    logic          err_now;
    logic          commit_idle, commit_wait, commit;
    logic          c_we, c_err;
    logic [AW-1:0] c_idx;
    logic [3:0]    c_sel;
    logic [31:0]   c_dat;
    logic [3:0]    ram_we;
    logic          ram_re;
    logic [31:0]   ram_q;

    // Byte-offset bits never select anything; folded here so they are consumed.
    logic unused_adr;
    assign unused_adr = ^{adr_i[31:AW+2], adr_i[1:0]};

`ifdef BEXKAT2_BUS_ERR_EN
    assign err_now = (adr_i[31:AW+2] != '0) | ~sel_legal(sel_i);
`else
    assign err_now = 1'b0;
`endif

    assign accept = (state_reg == R_IDLE) & cyc_i & stb_i;

    // The commit edge is the edge entering R_ACK. With no wait states that is
    // the acceptance edge itself, so the live bus inputs are used directly.
    assign commit_idle = accept & (WAIT == 0);
    assign commit_wait = (state_reg == R_WAIT) & cyc_i & (count_reg == 4'd0);
    assign commit      = (commit_idle | commit_wait) & ~rst_i;

    assign c_we  = commit_idle ? we_i          : we_reg;
    assign c_idx = commit_idle ? adr_i[AW+1:2] : idx_reg;
    assign c_sel = commit_idle ? sel_i         : sel_reg;
    assign c_dat = commit_idle ? dat_i         : dat_reg;
    assign c_err = commit_idle ? err_now       : err_reg;

    assign ram_we = (commit & c_we & ~c_err) ? c_sel : 4'b0000;
    assign ram_re = commit & ~c_we & ~c_err;

    bexkat2_ram_bank #(
        .AW(AW)
    ) u_ram (
        .clk  (clk_i),
        .addr (c_idx),
        .we   (ram_we),
        .din  (c_dat),
        .re   (ram_re),
        .q    (ram_q)
    );

    // Next-state and wait-counter decode.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            R_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_next = R_ACK;
                    end else begin
                        state_next = R_WAIT;
                        count_next = WAIT_LOAD;
                    end
                end
            end
            R_WAIT: begin
                if (!cyc_i) begin
                    state_next = R_IDLE;
                end else if (count_reg == 4'd0) begin
                    state_next = R_ACK;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            R_ACK:   state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    // FSM state, request latch and read-data qualifier.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= R_IDLE;
            count_reg     <= 4'd0;
            we_reg        <= 1'b0;
            idx_reg       <= '0;
            sel_reg       <= 4'd0;
            dat_reg       <= 32'd0;
            err_reg       <= 1'b0;
            dat_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                we_reg  <= we_i;
                idx_reg <= adr_i[AW+1:2];
                sel_reg <= sel_i;
                dat_reg <= dat_i;
                err_reg <= err_now;
            end
            if (commit) begin
                if (c_err) begin
                    dat_valid_reg <= 1'b0;
                end else if (!c_we) begin
                    dat_valid_reg <= 1'b1;
                end
            end
        end
    end

    // dat_o shows the RAM read register once a read has committed; it is
    // forced to zero after reset and after an errored completion.
    assign dat_o   = dat_valid_reg ? ram_q : 32'd0;
    assign stall_o = (state_reg != R_IDLE);
    assign ack_o   = (state_reg == R_ACK) & ~err_reg;
    assign err_o   = (state_reg == R_ACK) & err_reg;

endmodule

// File: tb/tb_bexkat2_bus_responder.sv
// Scoreboard bench for bexkat2_bus_responder: instance 0 runs with WAIT=0,
// instance 1 with WAIT=3. Expected completions are queued at issue time and
// checked by a negedge monitor whenever a DUT presents ack_o or err_o.
module tb_bexkat2_bus_responder;

`ifdef BEXKAT2_BUS_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc     [2];
    logic        stb     [2];
    logic        we      [2];
    logic [31:0] adr     [2];
    logic [3:0]  sel     [2];
    logic [31:0] dat_in  [2];
    logic [31:0] dat_out [2];
    logic        ack     [2];
    logic        stall   [2];
    logic        err     [2];

    int cycle_n = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    typedef struct {
        int          cyc;
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_n <= cycle_n + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            bexkat2_bus_responder #(
                .AW   (10),
                .WAIT ((gi == 0) ? 0 : 3)
            ) u_dut (
                .clk_i   (clk),
                .rst_i   (rst),
                .cyc_i   (cyc[gi]),
                .stb_i   (stb[gi]),
                .we_i    (we[gi]),
                .adr_i   (adr[gi]),
                .sel_i   (sel[gi]),
                .dat_i   (dat_in[gi]),
                .dat_o   (dat_out[gi]),
                .ack_o   (ack[gi]),
                .stall_o (stall[gi]),
                .err_o   (err[gi])
            );
        end
    endgenerate

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cycle_n);
        end else begin
            $display("ok   %s: 0x%08h", nm, act);
        end
    endtask

    // Issue one full transaction; called #1 after a rising edge with the DUT idle.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic chk_rd, input logic [31:0] rd,
                       input logic e_err, input string nm);
        exp_t e;
        e.cyc     = cycle_n + 1 + wait_of(d);
        e.is_err  = e_err;
        e.chk_dat = chk_rd | e_err;
        e.dat     = e_err ? 32'd0 : rd;
        e.name    = nm;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_in[d] = wd;
        @(posedge clk);
        #1 stb[d] = 1'b0;
        repeat (wait_of(d)) @(posedge clk);
        #1 cyc[d] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Issue a write that will be abandoned; the caller ends it.
    task automatic start_write(input int d, input logic [31:0] a, input logic [31:0] wd);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; sel[d] = 4'b1111; dat_in[d] = wd;
        @(posedge clk);
        #1 stb[d] = 1'b0;
    endtask

    task automatic check_out(input int d);
        exp_t e;
        logic empty;
        if (ack[d] === 1'b1 || err[d] === 1'b1) begin
            n_cmp++;
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_bad++;
                $display("FAIL unexpected_completion dut%0d cycle %0d: got ack=%b err=%b expected no completion",
                         d, cycle_n, ack[d], err[d]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (cycle_n != e.cyc || err[d] !== e.is_err || ack[d] !== !e.is_err ||
                    stall[d] !== 1'b1 || (e.chk_dat && dat_out[d] !== e.dat)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: got cycle=%0d ack=%b err=%b stall=%b dat=0x%08h expected cycle=%0d err=%b stall=1 dat=0x%08h",
                             e.name, d, cycle_n, ack[d], err[d], stall[d], dat_out[d], e.cyc, e.is_err, e.dat);
                end else begin
                    $display("ok   %s dut%0d: cycle=%0d err=%b dat=0x%08h", e.name, d, cycle_n, err[d], dat_out[d]);
                end
            end
        end
    endtask

    // Monitor: compare each completion against the oldest queued expectation.
    always @(negedge clk) begin
        check_out(0);
        check_out(1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = 32'd0; sel[d] = 4'd0; dat_in[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ack%0d", d),   {31'd0, ack[d]},   32'd0);
            chk($sformatf("reset_stall%0d", d), {31'd0, stall[d]}, 32'd0);
            chk($sformatf("reset_err%0d", d),   {31'd0, err[d]},   32'd0);
            chk($sformatf("reset_dat%0d", d),   dat_out[d],        32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // WAIT=0 instance: full word, lane write, empty select, alias / error.
        txn(0, 1'b1, 32'h40, 4'b1111, 32'h12345678, 1'b0, 32'd0, 1'b0, "w0_40_word");
        txn(0, 1'b0, 32'h40, 4'b1111, 32'd0, 1'b1, 32'h12345678, 1'b0, "r0_40_word");
        txn(0, 1'b1, 32'h40, 4'b0010, 32'h0000AB00, 1'b0, 32'd0, 1'b0, "w0_40_lane1");
        txn(0, 1'b0, 32'h40, 4'b1111, 32'd0, 1'b1, 32'h1234AB78, 1'b0, "r0_40_lane1");
        txn(0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, "w0_40_sel0");
        txn(0, 1'b0, 32'h40, 4'b0000, 32'd0, 1'b1, 32'h1234AB78, 1'b0, "r0_40_sel0");
        txn(0, 1'b1, 32'h0, 4'b1111, 32'h0BADCAFE, 1'b0, 32'd0, 1'b0, "w0_00_word");
        txn(0, 1'b1, 32'h1000, 4'b1111, 32'h55AA55AA, 1'b0, 32'd0, ERR, "w0_1000_alias");
        txn(0, 1'b0, 32'h0, 4'b1111, 32'd0, 1'b1, ERR ? 32'h0BADCAFE : 32'h55AA55AA, 1'b0, "r0_00_alias");
        txn(0, 1'b1, 32'h44, 4'b1111, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, "w0_44_word");
        txn(0, 1'b1, 32'h44, 4'b0101, 32'h00000000, 1'b0, 32'd0, ERR, "w0_44_sel0101");
        txn(0, 1'b0, 32'h47, 4'b1111, 32'd0, 1'b1, ERR ? 32'hFFFFFFFF : 32'hFF00FF00, 1'b0, "r0_47_lowbits");

        // WAIT=3 instance: latency, lane write, cyc drop abort, reset abort.
        txn(1, 1'b1, 32'h80, 4'b1111, 32'h11112222, 1'b0, 32'd0, 1'b0, "w1_80_word");
        txn(1, 1'b0, 32'h80, 4'b1111, 32'd0, 1'b1, 32'h11112222, 1'b0, "r1_80_word");
        txn(1, 1'b1, 32'h80, 4'b1000, 32'hAB000000, 1'b0, 32'd0, 1'b0, "w1_80_lane3");
        txn(1, 1'b0, 32'h80, 4'b1111, 32'd0, 1'b1, 32'hAB112222, 1'b0, "r1_80_lane3");

        start_write(1, 32'h80, 32'h99999999);
        @(posedge clk);
        #1 cyc[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cyc_stall1", {31'd0, stall[1]}, 32'd0);
        txn(1, 1'b0, 32'h80, 4'b1111, 32'd0, 1'b1, 32'hAB112222, 1'b0, "r1_80_after_abort");

        txn(1, 1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0, "w1_10_prior");
        start_write(1, 32'h10, 32'hDEADBEEF);
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        cyc[1] = 1'b0;
        chk("abort_rst_stall1", {31'd0, stall[1]}, 32'd0);
        chk("abort_rst_ack1",   {31'd0, ack[1]},   32'd0);
        @(posedge clk);
        #1;
        txn(1, 1'b0, 32'h10, 4'b1111, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0, "r1_10_after_rst");

        repeat (6) @(posedge clk);
        #1;
        chk("pending_dut0", 32'(q0.size()), 32'd0);
        chk("pending_dut1", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
